// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core's fetch/data ports, the arbiter and the shared memory bus.
// The master view belongs to the arbiter; the slave view is the core plus memory side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;

    logic        dm_read;
    logic [1:0]  dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        dm_stall;

    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, bus_rdata, bus_ack,
        output if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
        output bus_req, bus_we, bus_size, bus_addr, bus_wdata, bus_err
    );

    modport slave (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, bus_rdata, bus_ack,
        input  if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
        input  bus_req, bus_we, bus_size, bus_addr, bus_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the instruction-fetch and data ports, one transaction
// at a time, with round-robin tie breaking and an ack timeout that returns a safe value.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_port_arbiter_if.master  port
);

    typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT} state_t;

    state_t     state;
    state_t     state_next;
    logic       last_dm;
    logic [7:0] wait_cnt;
    logic       dm_active;
    logic       if_elig;
    logic       dm_elig;
    logic       grant_if;
    logic       grant_dm;
    logic       finish;
    logic       timed_out;
    logic       last_wait;

    assign dm_active     = port.dm_read | (|port.dm_write);
    assign if_elig       = port.if_req & ~port.if_ready;
    assign dm_elig       = dm_active & ~port.dm_ready;
    assign port.if_stall = port.if_req & ~port.if_ready;
    assign port.dm_stall = dm_active & ~port.dm_ready;

    // wait_cnt holds the wait cycles already elapsed, so this flags the TIMEOUT-th one
    assign last_wait = (({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        finish     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (if_elig && (!dm_elig || last_dm)) begin
                    grant_if   = 1'b1;
                    state_next = IF_WAIT;
                end else if (dm_elig) begin
                    grant_dm   = 1'b1;
                    state_next = DM_WAIT;
                end
            end
            IF_WAIT, DM_WAIT: begin
                if (port.bus_ack) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (last_wait) begin
                    finish     = 1'b1;
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port.bus_req   <= 1'b0;
            port.bus_we    <= 1'b0;
            port.bus_size  <= 2'b00;
            port.bus_addr  <= '0;
            port.bus_wdata <= '0;
            port.bus_err   <= 1'b0;
            port.if_rdata  <= '0;
            port.if_ready  <= 1'b0;
            port.dm_rdata  <= '0;
            port.dm_ready  <= 1'b0;
            last_dm        <= 1'b0;
            wait_cnt       <= '0;
        end else begin
            port.if_ready <= 1'b0;
            port.dm_ready <= 1'b0;

            if (grant_if || grant_dm) begin
                port.bus_req <= 1'b1;
                wait_cnt     <= '0;
            end else if (state != IDLE) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            // a nonzero MemWrite makes it a store regardless of MemRead
            if (grant_if) begin
                port.bus_we    <= 1'b0;
                port.bus_size  <= 2'b00;
                port.bus_addr  <= port.if_addr;
                port.bus_wdata <= '0;
            end else if (grant_dm) begin
                port.bus_we    <= |port.dm_write;
                port.bus_size  <= port.dm_write;
                port.bus_addr  <= port.dm_addr;
                port.bus_wdata <= port.dm_wdata;
            end

            if (finish) begin
                port.bus_req <= 1'b0;
                if (timed_out) begin
                    port.bus_err <= 1'b1;
                end else begin
                    last_dm <= (state == DM_WAIT);
                end
                if (state == IF_WAIT) begin
                    port.if_ready <= 1'b1;
                    port.if_rdata <= timed_out ? NOP_INSN : port.bus_rdata;
                end else begin
                    port.dm_ready <= 1'b1;
                    port.dm_rdata <= (timed_out || port.bus_we) ? '0 : port.bus_rdata;
                end
            end
        end
    end

endmodule
